// File: rtl/signed_comparator_unit_pkg.sv
// cmp_pkg: shared width and word type for the signed comparator datapath.
package cmp_pkg;
    localparam int CMP_WIDTH = 32;
    typedef logic [CMP_WIDTH-1:0] word_t;
endpackage

// File: rtl/signed_comparator_unit_slice.sv
// comparator_lt_slice: one MSB-first cell of the magnitude/equality ripple chain.
module comparator_lt_slice (
    input  logic a_i,
    input  logic b_i,
    input  logic lt_in,
    input  logic eq_in,
    output logic lt_out,
    output logic eq_out
);
    assign lt_out = lt_in | (eq_in & ~a_i & b_i);
    assign eq_out = eq_in & ~(a_i ^ b_i);
endmodule

// File: rtl/signed_comparator_unit.sv
// signed_comparator_unit: gate-level signed == and < with a registered copy.
module signed_comparator_unit
    import cmp_pkg::*;
#(
    parameter int N = CMP_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         equals,
    output logic         less_than,
    output logic         eq_q,
    output logic         lt_q
);
    logic [N-1:0] w_lt;
    logic [N-1:0] w_eq;
    logic         w_sign_diff;
    assign w_lt[N-1] = 1'b0;
    assign w_eq[N-1] = 1'b1;
    genvar i;
    generate
        for (i = N - 2; i >= 0; i--) begin : g_slice
            comparator_lt_slice u_slice (
                .a_i   (a[i]),
                .b_i   (b[i]),
                .lt_in (w_lt[i+1]),
                .eq_in (w_eq[i+1]),
                .lt_out(w_lt[i]),
                .eq_out(w_eq[i])
            );
        end
    endgenerate
    assign w_sign_diff = a[N-1] ^ b[N-1];
    assign equals      = w_eq[0] & ~w_sign_diff;
    // Differing signs: the negative operand is the smaller one.
    assign less_than   = w_sign_diff ? a[N-1] : w_lt[0];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_q <= 1'b0;
            lt_q <= 1'b0;
        end else begin
            eq_q <= equals;
            lt_q <= less_than;
        end
    end
endmodule

// File: tb/tb_signed_comparator_unit.sv
// tb_signed_comparator_unit: directed table, reset/latency sequences and random sweep.
module tb_signed_comparator_unit;
    import cmp_pkg::*;
    typedef struct {
        word_t a;
        word_t b;
        logic  eq;
        logic  lt;
    } vec_t;
    logic  clk = 1'b0;
    logic  rst = 1'b1;
    word_t a = '0;
    word_t b = '0;
    logic  equals, less_than, eq_q, lt_q;
    int    passed = 0;
    int    total = 0;
    vec_t  v [13];
    logic  exp_eq, exp_lt;
    signed_comparator_unit #(.N(CMP_WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .equals   (equals),
        .less_than(less_than),
        .eq_q     (eq_q),
        .lt_q     (lt_q)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s a=%h b=%h actual=%b required=%b", name, a, b, act, exp);
    endtask
    initial begin
        v[0]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        v[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1};
        v[2]  = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0};
        v[3]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 1'b0, 1'b1};
        v[4]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0};
        v[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0};
        v[6]  = '{32'd38273,     32'd38273,     1'b1, 1'b0};
        v[7]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
        v[8]  = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0};
        v[9]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1};
        v[10] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1};
        v[11] = '{32'h0000_0005, 32'h0000_0004, 1'b0, 1'b0};
        v[12] = '{32'h4000_0000, 32'h4000_0001, 1'b0, 1'b1};
        #1;
        chk("reset_eq_q", eq_q, 1'b0);
        chk("reset_lt_q", lt_q, 1'b0);
        @(posedge clk);
        #1;
        chk("reset_hold_eq_q", eq_q, 1'b0);
        chk("reset_hold_lt_q", lt_q, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            a = v[k].a;
            b = v[k].b;
            #1;
            chk("tbl_equals", equals, v[k].eq);
            chk("tbl_less_than", less_than, v[k].lt);
            @(posedge clk);
            #1;
            chk("tbl_eq_q", eq_q, v[k].eq);
            chk("tbl_lt_q", lt_q, v[k].lt);
        end
        @(negedge clk);
        a = 32'hFFFF_FFFD;
        b = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        chk("seq_lt_q_capture", lt_q, 1'b1);
        chk("seq_eq_q_capture", eq_q, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("seq_async_rst_lt_q", lt_q, 1'b0);
        chk("seq_rst_comb_lt", less_than, 1'b1);
        @(posedge clk);
        #1;
        chk("seq_rst_hold_lt_q", lt_q, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("seq_release_no_edge", lt_q, 1'b0);
        @(posedge clk);
        #1;
        chk("seq_recapture_lt_q", lt_q, 1'b1);
        chk("seq_recapture_eq_q", eq_q, 1'b0);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            a = $random;
            b = (k % 8 == 0) ? a : $random;
            exp_eq = (a == b);
            exp_lt = ($signed(a) < $signed(b));
            #1;
            chk("rnd_equals", equals, exp_eq);
            chk("rnd_less_than", less_than, exp_lt);
            @(posedge clk);
            #1;
            chk("rnd_eq_q", eq_q, exp_eq);
            chk("rnd_lt_q", lt_q, exp_lt);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
